// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: walks fetch/decode/execute states and decodes datapath strobes from state.
// MEM_WAIT_EN: when defined, F1/L1/S2 stall on mem_ready; otherwise every memory state lasts one cycle.
`timescale 1ns/1ps
module control_unit #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    input  logic              stop,
    output logic              pc_out,
    output logic              zlo_out,
    output logic              zhi_out,
    output logic              mdr_out,
    output logic              c_out,
    output logic              ba_out,
    output logic              r_out,
    output logic              mar_enable,
    output logic              mdr_enable,
    output logic              ir_enable,
    output logic              y_enable,
    output logic              z_enable,
    output logic              pc_enable,
    output logic              pc_increment,
    output logic              lo_enable,
    output logic              hi_enable,
    output logic              r_in,
    output logic              read,
    output logic              write,
    output logic              gra,
    output logic              grb,
    output logic              grc,
    output logic [OP_W-1:0]   op_code,
    output logic              run
);

    typedef enum logic [4:0] {
        S_RST, S_F0, S_F1, S_F2, S_F3,
        S_E1, S_E2, S_E2I, S_E3,
        S_U1, S_U2,
        S_M1, S_M2, S_M3, S_M4,
        S_A1, S_A2, S_A3,
        S_L1, S_L2, S_S1, S_S2,
        S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_LD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3);

    state_t          state;
    state_t          state_nxt;
    logic [OP_W-1:0] ir_op;
    logic [OP_W-1:0] op_q;
    logic            stop_req;
    logic            halt_now;
    logic            mem_go;
    logic            unused_ir;

    assign ir_op     = ir[DATA_W-1 -: OP_W];
    assign unused_ir = ^ir[DATA_W-OP_W-1:0];
    assign halt_now  = stop | stop_req;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        return (op >= OP_W'(3)) && (op <= OP_W'(11));
    endfunction

    function automatic logic is_itype(input logic [OP_W-1:0] op);
        return (op >= OP_W'(12)) && (op <= OP_W'(14));
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_W'(15)) || (op == OP_W'(16));
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_W'(17)) || (op == OP_W'(18));
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return op <= OP_W'(2);
    endfunction

    // Opcode is captured as decode completes so later states do not depend on IR staying put;
    // a stop request is remembered until the instruction boundary.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_RST;
            op_q     <= '0;
            stop_req <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_F3)
                op_q <= ir_op;
            if (run)
                stop_req <= stop_req | stop;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_F0;
            S_F0:   state_nxt = S_F1;
            S_F1:   if (mem_go) state_nxt = S_F2;
            S_F2:   state_nxt = S_F3;
            S_F3: begin
                if (is_rtype(ir_op) || is_itype(ir_op)) state_nxt = S_E1;
                else if (is_unary(ir_op))               state_nxt = S_U1;
                else if (is_muldiv(ir_op))              state_nxt = S_M1;
                else if (is_mem(ir_op))                 state_nxt = S_A1;
                else                                    state_nxt = S_HALT;
            end
            S_E1:   state_nxt = is_itype(op_q) ? S_E2I : S_E2;
            S_E2,
            S_E2I:  state_nxt = S_E3;
            S_U1:   state_nxt = S_U2;
            S_M1:   state_nxt = S_M2;
            S_M2:   state_nxt = S_M3;
            S_M3:   state_nxt = S_M4;
            S_A1:   state_nxt = S_A2;
            S_A2:   state_nxt = S_A3;
            S_A3: begin
                if (op_q == OP_LDI)     state_nxt = halt_now ? S_HALT : S_F0;
                else if (op_q == OP_LD) state_nxt = S_L1;
                else                    state_nxt = S_S1;
            end
            S_L1:   if (mem_go) state_nxt = S_L2;
            S_S1:   state_nxt = S_S2;
            S_S2:   if (mem_go) state_nxt = halt_now ? S_HALT : S_F0;
            S_E3,
            S_U2,
            S_M4,
            S_L2:   state_nxt = halt_now ? S_HALT : S_F0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        c_out        = 1'b0;
        ba_out       = 1'b0;
        r_out        = 1'b0;
        mar_enable   = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        r_in         = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        gra          = 1'b0;
        grb          = 1'b0;
        grc          = 1'b0;
        op_code      = '0;
        run          = (state != S_RST) && (state != S_HALT);
        case (state)
            S_F0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; end
            S_F1: begin read = 1'b1; mdr_enable = 1'b1; end
            S_F2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            S_E1: begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
            S_E2: begin grc = 1'b1; r_out = 1'b1; op_code = op_q; z_enable = 1'b1; end
            S_E2I: begin c_out = 1'b1; op_code = op_q; z_enable = 1'b1; end
            S_E3, S_U2: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_U1: begin grb = 1'b1; r_out = 1'b1; op_code = op_q; z_enable = 1'b1; end
            S_M1: begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
            S_M2: begin grb = 1'b1; r_out = 1'b1; op_code = op_q; z_enable = 1'b1; end
            S_M3: begin zlo_out = 1'b1; lo_enable = 1'b1; end
            S_M4: begin zhi_out = 1'b1; hi_enable = 1'b1; end
            S_A1: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
            S_A2: begin c_out = 1'b1; op_code = OP_ADD; z_enable = 1'b1; end
            S_A3: begin
                zlo_out = 1'b1;
                if (op_q == OP_LDI) begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                end else begin
                    mar_enable = 1'b1;
                end
            end
            S_L1: begin read = 1'b1; mdr_enable = 1'b1; end
            S_L2: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_S1: begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
            S_S2: write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer for the phase-3 datapath.
- Generates every datapath strobe that the bench currently drives by hand: fetch, decode, execute and writeback for the ALU, immediate, unary, mul/div and load/store instructions.
- Sits beside Datapath, driven by the IR contents and a memory-ready handshake.
- Outputs feed Datapath bus-select/enable inputs and the select-and-encode logic through gra/grb/grc, r_in, r_out, ba_out and c_out.

Parameters:
- DATA_W, 32, instruction/IR width.
- OP_W, 5, opcode width (IR[31:27]).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents. Fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- mem_ready  in  1  memory read/write completion handshake.
- stop  in  1  request halt at the next instruction boundary.
- pc_out, zlo_out, zhi_out, mdr_out, c_out, ba_out, r_out  out  1 each  bus drivers.
- mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, pc_increment, lo_enable, hi_enable, r_in  out  1 each  register loads.
- read, write  out  1 each  memory strobes.
- gra, grb, grc  out  1 each  register-field selects for select-and-encode.
- op_code  out  5  ALU operation.
- run  out  1  high while executing; low in HALT.

Behaviour:
- Reset: clr=0 forces state RST immediately. All outputs are 0, including op_code=0 and run=0.
  - A mid-instruction reset aborts the instruction with no further strobes.
  - First rising edge after clr deasserts: RST -> F0.
- Moore outputs are decoded from the registered state only. Exactly one state per clock, except wait states.
- run=1 in every state except RST and HALT.
- Fetch:
  - F0: pc_out, mar_enable, pc_increment.
  - F1: read, mdr_enable. Holds until mem_ready=1.
  - F2: mdr_out, ir_enable.
  - F3: decode-only state, no strobes; branches on ir[31:27].
- R-type (add..shl, opcodes 3-11):
  - E1: grb, r_out, y_enable.
  - E2: grc, r_out, op_code=op, z_enable.
  - E3: zlo_out, gra, r_in. Then F0.
- I-type (addi/andi/ori, opcodes 12-14):
  - E1 as R-type.
  - E2: c_out, op_code=op, z_enable.
  - E3 as R-type.
- neg/not (opcodes 17, 18):
  - U1: grb, r_out, op_code=op, z_enable.
  - U2: zlo_out, gra, r_in.
- mul/div (opcodes 16, 15):
  - M1: gra, r_out, y_enable.
  - M2: grb, r_out, op_code=op, z_enable.
  - M3: zlo_out, lo_enable.
  - M4: zhi_out, hi_enable.
- ld/ldi/st (opcodes 0, 1, 2), common front:
  - A1: grb, ba_out, y_enable.
  - A2: c_out, op_code=3 (add), z_enable.
- ldi: A3: zlo_out, gra, r_in.
- ld:
  - A3: zlo_out, mar_enable.
  - L1: read, mdr_enable, held until mem_ready.
  - L2: mdr_out, gra, r_in.
- st:
  - A3: zlo_out, mar_enable.
  - S1: gra, r_out, mdr_enable, read=0.
  - S2: write, held until mem_ready.
- Opcode 19-31 (undefined) -> HALT.
- HALT: all strobes 0, run=0. Exits only through reset.
- stop: sampled in the final execute state of each instruction. If 1, next state is HALT instead of F0. stop asserted mid-instruction does not truncate the instruction.
- op_code holds the current instruction's opcode only in ALU-operating states; it is 0 elsewhere.
- Wait states: mem_ready=1 on the first cycle of F1/L1/S2 means no extra cycle. Strobes stay asserted for every wait cycle.
- Latency, no waits: R-type 7 cycles, I-type 7, neg/not 6, mul/div 8, ldi 7, ld 9, st 9 (F0 to last state inclusive).

Optional Feature:
- MEM_WAIT_EN.
- Defined: F1, L1 and S2 stall on mem_ready as above.
- Undefined: mem_ready is ignored; each memory state lasts exactly one cycle (single-cycle synchronous memory). The port remains present but unused.

Test Plan:
- Reset: clr=0 asserted mid-E2 of an add -> all outputs 0 and run=0 within the same cycle, with no clk edge. Release -> F0 next edge with pc_out=1, mar_enable=1, pc_increment=1.
- shr: ir=0x4A1B8000 (shr R4,R3,R7), mem_ready tied 1 -> E1 grb/r_out/y_enable; E2 grc/r_out/z_enable with op_code=5'b01001; E3 zlo_out/gra/r_in. Next cycle returns to F0; total 7 cycles.
- mul: ir op=16 -> M1..M4 in order; lo_enable one cycle then hi_enable one cycle; op_code=5'b10000 only in M2.
- ld with MEM_WAIT_EN: mem_ready held low 3 cycles in L1 -> read/mdr_enable high 4 cycles, then L2 r_in with gra. Without MEM_WAIT_EN -> L1 exactly 1 cycle.
- st: op=2 -> S1 r_out/gra/mdr_enable with read=0; S2 write=1 until mem_ready; no r_in asserted at any point.
- Halt paths: stop pulsed during E1 of add -> add completes E3, then HALT with run=0. Separately, ir op=5'b11111 -> HALT directly after F3.
